// File: rtl/twos_comp_seq_pkg.sv
// Shared definitions for the sequential two's-complement controller:
// state encoding, default geometry and the bit-counter width helper.
package twos_comp_seq_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_LAT   = 1;

    // Controller state enumeration, kept as plain constants for legacy tools
    typedef logic [1:0] tc_state_t;
    localparam tc_state_t ST_IDLE  = 2'd0;
    localparam tc_state_t ST_SHIFT = 2'd1;
    localparam tc_state_t ST_DRAIN = 2'd2;
    localparam tc_state_t ST_DONE  = 2'd3;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/tc_seq_shreg.sv
// Right-shifting register with parallel load; serial data enters at the MSB.
module tc_seq_shreg
    import twos_comp_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_val;
        end else if (shift_en) begin
            data_q <= {ser_in, data_q[WIDTH-1:1]};
        end
    end

    assign q = data_q;

endmodule

// File: rtl/twos_comp_seq_ctrl.sv
// Serialises an operand LSB-first to an external negator and collects its reply.
// Optional ovf output for the most-negative operand: define TWOS_COMP_SEQ_OVF_EN.
module twos_comp_seq_ctrl
    import twos_comp_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LAT   = DEF_LAT
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef TWOS_COMP_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             ser_i,
    output logic             ser_r,
    input  logic             ser_y
);

    localparam int unsigned    CW         = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  LAST_DRAIN = (LAT > 0) ? CW'(LAT - 1) : '0;

    tc_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             in_shift;
    logic             cap_en;
    logic [WIDTH-1:0] op_q;
    logic             unused_op;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = (LAT > 0) ? ST_DRAIN : ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge t_clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_shift = (state_q == ST_SHIFT);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign ser_i    = in_shift & op_q[0];
    assign ser_r    = in_shift & (cnt_q == '0);

    // Capture window is the shift window delayed by the datapath latency
    if (LAT > 0) begin : g_cap_dly
        logic [LAT-1:0] vld_q;
        logic [LAT:0]   vld_d;
        assign vld_d = {vld_q, in_shift};
        always_ff @(posedge t_clk) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d[LAT-1:0];
            end
        end
        assign cap_en = vld_d[LAT];
    end else begin : g_cap_now
        assign cap_en = in_shift;
    end

    tc_seq_shreg #(.WIDTH(WIDTH)) u_ser (
        .clk      (t_clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (operand),
        .shift_en (in_shift),
        .ser_in   (1'b0),
        .q        (op_q)
    );

    tc_seq_shreg #(.WIDTH(WIDTH)) u_des (
        .clk      (t_clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val ({WIDTH{1'b0}}),
        .shift_en (cap_en),
        .ser_in   (ser_y),
        .q        (result)
    );

    assign unused_op = ^op_q[WIDTH-1:1];

`ifdef TWOS_COMP_SEQ_OVF_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic ovf_pend_q, ovf_q;

    always_ff @(posedge t_clk) begin
        if (!rst_n) begin
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            ovf_pend_q <= (operand == MIN_NEG);
            ovf_q      <= 1'b0;
        end else if (state_d == ST_DONE && state_q != ST_DONE) begin
            ovf_q <= ovf_pend_q;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_twos_comp_seq_ctrl.sv
// Self-checking bench for twos_comp_seq_ctrl with a behavioural serial negator.
module tb_twos_comp_seq_ctrl;

    localparam int W = 8;
    localparam int L = 1;

    logic         t_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] operand = '0;
    logic         busy, done, ser_i, ser_r, ser_y;
    logic [W-1:0] result;
`ifdef TWOS_COMP_SEQ_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 t_clk = ~t_clk;

    twos_comp_seq_ctrl #(.WIDTH(W), .LAT(L)) dut (
        .t_clk   (t_clk),
        .rst_n   (rst_n),
        .start   (start),
        .operand (operand),
        .busy    (busy),
        .done    (done),
        .result  (result),
`ifdef TWOS_COMP_SEQ_OVF_EN
        .ovf     (ovf),
`endif
        .ser_i   (ser_i),
        .ser_r   (ser_r),
        .ser_y   (ser_y)
    );

    // Serial negator: pass bits up to and including the first 1, invert afterwards
    logic       seen = 1'b0;
    logic       y_now;
    logic [3:0] dly_q = '0;
    logic [4:0] tap;

    always_comb begin
        y_now = (seen && !ser_r) ? ~ser_i : ser_i;
    end
    assign tap   = {dly_q, y_now};
    assign ser_y = tap[L];

    always @(posedge t_clk) begin
        seen  <= (seen && !ser_r) | ser_i;
        dly_q <= tap[3:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    // Issue one word from IDLE and check latency, marker, result and return to IDLE
    task automatic run_op(input string tag, input logic [W-1:0] op);
        logic [W-1:0] exp_res;
        int           k;
        int           nr;
        logic         r_first;
        exp_res = '0 - op;
        start   = 1'b1;
        operand = op;
        tick();
        start   = 1'b0;
        operand = W'($urandom);
        k       = 1;
        nr      = 0;
        r_first = ser_r;
        chk({tag, " busy_first_shift"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && k < 40) begin
            if (ser_r) nr++;
            tick();
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(W + L + 1));
        chk({tag, " ser_r_first"}, 32'(r_first), 32'd1);
        chk({tag, " ser_r_count"}, 32'(nr), 32'd1);
        chk({tag, " result"}, 32'(result), 32'(exp_res));
        chk({tag, " ser_in_done"}, 32'({ser_i, ser_r}), 32'd0);
`ifdef TWOS_COMP_SEQ_OVF_EN
        chk({tag, " ovf"}, 32'(ovf), 32'(op == {1'b1, {(W-1){1'b0}}}));
`endif
        tick();
        chk({tag, " idle_flags"}, 32'({done, busy, ser_i, ser_r}), 32'd0);
        chk({tag, " result_held"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ops[30];
        int           done_at[$];
        logic [W-1:0] done_val[$];
        int           acc_next;
        int           c;
        int           ndone;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset flags", 32'({busy, done, ser_i, ser_r}), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle after reset", 32'({busy, done}), 32'd0);

        // Directed operands
        run_op("op06", 8'h06);
        run_op("op00", 8'h00);
        run_op("op01", 8'h01);
        run_op("op7f", 8'h7F);
        run_op("op80", 8'h80);
        run_op("opff", 8'hFF);

        // Random operands
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("rnd%0d", i), W'($urandom));
        end

        // Start held high every cycle: accepts only in IDLE, words never overlap
        acc_next = 0;
        for (int i = 0; i < 30; i++) begin
            ops[i]  = W'($urandom);
            operand = ops[i];
            start   = 1'b1;
            if (i == acc_next) begin
                done_at.push_back(i + W + L + 1);
                done_val.push_back('0 - ops[i]);
                acc_next += W + L + 2;
            end
            if (done_at.size() > 0 && done_at[0] == i) begin
                chk($sformatf("burst done c%0d", i), 32'(done), 32'd1);
                chk($sformatf("burst result c%0d", i), 32'(result), 32'(done_val[0]));
                void'(done_at.pop_front());
                void'(done_val.pop_front());
            end else begin
                chk($sformatf("burst nodone c%0d", i), 32'(done), 32'd0);
            end
            tick();
        end
        start = 1'b0;
        c = 30;
        while (done !== 1'b1 && c < 60) begin
            tick();
            c++;
        end
        chk("burst last done cycle", 32'(c), 32'(done_at[0]));
        chk("burst last result", 32'(result), 32'(done_val[0]));
        tick();

        // Reset in the 4th shift cycle aborts the word
        start   = 1'b1;
        operand = W'($urandom);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre-abort busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort flags", 32'({busy, done, ser_i, ser_r}), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("abort no done", 32'(ndone), 32'd0);
        chk("abort stays idle", 32'({busy, result}), 32'd0);
        run_op("after_abort05", 8'h05);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/twos_comp_seq_ctrl.md
TWOS_COMP_SEQ_CTRL -- requirements
Module: twos_comp_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result word width in bits (legal range 2..32).
REQ-002 SHALL have parameter LAT, default 1, giving the cycles from ser_i being driven to the matching ser_y being valid (legal range 0..3).
REQ-003 t_clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to negate operand; sampled only in IDLE.
REQ-006 operand  input  WIDTH  parallel word to negate, captured when start is accepted.
REQ-007 busy  output  1  high from the cycle after start is accepted through the cycle done is high.
REQ-008 done  output  1  one-cycle pulse when result is valid.
REQ-009 result  output  WIDTH  two's complement of the captured operand; held until the next accepted start.
REQ-010 ser_i  output  1  serial bit to datapath, LSB first.
REQ-011 ser_r  output  1  word-start marker to datapath; high only with bit 0 of each word.
REQ-012 ser_y  input  1  serial result bit from datapath.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DRAIN, DONE.
REQ-014 IDLE: start=1 -> capture operand into shift register, clear bit counter, go to SHIFT; otherwise stay.
REQ-015 SHIFT: drive ser_i = current LSB, ser_r = (bit counter == 0), shift right, increment counter; after WIDTH bits go to DRAIN (LAT>0) or DONE (LAT=0).
REQ-016 DRAIN: drive ser_i=0, ser_r=0 for exactly LAT cycles, then go to DONE.
REQ-017 Capture: ser_y SHALL be shifted into the result register MSB-side, LAT cycles after each SHIFT-cycle bit, for exactly WIDTH samples; bits outside that window are ignored.
REQ-018 DONE: done=1 for one cycle, result stable, then return to IDLE.
REQ-019 Latency: first accepted start at edge N -> done high in cycle N+WIDTH+LAT+1.
REQ-020 start while busy SHALL be ignored (not queued); start in the DONE cycle is ignored; start in the cycle after done is accepted.
REQ-021 ser_i and ser_r SHALL be 0 in IDLE and DONE.
REQ-022 operand changes after acceptance SHALL not affect the computation in progress.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, ser_i=0, ser_r=0, counters=0.
REQ-024 Reset mid-operation SHALL abort the word with no done pulse; the first start after reset release is accepted normally.

Configuration
REQ-025 With macro TWOS_COMP_SEQ_OVF_EN defined, an extra output ovf (1 bit) SHALL be present; it is set in the DONE cycle when the captured operand equals the most-negative value (MSB=1, rest 0), held with result, and cleared on reset or the next accepted start.
REQ-026 Without TWOS_COMP_SEQ_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package twos_comp_seq_pkg SHALL hold the FSM state enum, default WIDTH and LAT constants, and the counter width function (clog2 of WIDTH+1).
REQ-028 One sub-module, tc_seq_shreg (parameterised-width shift register with load, shift-enable and serial-in), SHALL be instantiated twice: operand serializer and result deserializer.

Verification
REQ-029 Bench SHALL model the datapath as a serial negator (copy bits through first 1, invert after; ser_r clears state) with LAT-cycle delay.
REQ-030 WIDTH=8, LAT=1: operand 8'h06 -> result 8'hFA, done 10 cycles after start edge, ser_r high only on the first SHIFT cycle.
REQ-031 operand 8'h00 -> result 8'h00; operand 8'h01 -> 8'hFF; operand 8'h7F -> 8'h81.
REQ-032 operand 8'h80 -> result 8'h80; ovf=1 with TWOS_COMP_SEQ_OVF_EN, port absent without it.
REQ-033 start pulsed on every cycle for 30 cycles -> accepted only in IDLE, done every 11 cycles, no overlap of words.
REQ-034 rst_n=0 for one cycle in the 4th SHIFT cycle -> no done, outputs 0; next start with 8'h05 -> result 8'hFB.
